// File: rtl/ps2_vga_pkg.sv
// Shared scan codes, command set and FSM states for the PS/2-driven sprite plotter.
package ps2_vga_pkg;

    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_BREAK = 8'hF0;
    localparam logic [7:0] SC_UP    = 8'h75;
    localparam logic [7:0] SC_DOWN  = 8'h72;
    localparam logic [7:0] SC_LEFT  = 8'h6B;
    localparam logic [7:0] SC_RIGHT = 8'h74;
    localparam logic [7:0] SC_C     = 8'h21;
    localparam logic [7:0] SC_SPACE = 8'h29;

    typedef enum logic [2:0] {
        CMD_NONE,
        CMD_UP,
        CMD_DOWN,
        CMD_LEFT,
        CMD_RIGHT,
        CMD_COLOUR,
        CMD_CENTRE
    } cmd_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ERASE,
        ST_UPDATE,
        ST_DRAW
    } state_t;

endpackage

// File: rtl/ps2_scancode_decoder.sv
// Tracks E0/F0 prefixes and turns completed make codes into one-cycle command pulses.
module ps2_scancode_decoder
    import ps2_vga_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] ps2_byte,
    input  logic       ps2_byte_valid,
    output cmd_t       cmd,
    output logic       cmd_valid
);

    logic ext;
    logic brk;
    cmd_t decoded;

    always_comb begin
        decoded = CMD_NONE;
        if (ext) begin
            case (ps2_byte)
                SC_UP:    decoded = CMD_UP;
                SC_DOWN:  decoded = CMD_DOWN;
                SC_LEFT:  decoded = CMD_LEFT;
                SC_RIGHT: decoded = CMD_RIGHT;
                default:  decoded = CMD_NONE;
            endcase
        end else begin
            case (ps2_byte)
                SC_C:     decoded = CMD_COLOUR;
                SC_SPACE: decoded = CMD_CENTRE;
                default:  decoded = CMD_NONE;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ext       <= 1'b0;
            brk       <= 1'b0;
            cmd       <= CMD_NONE;
            cmd_valid <= 1'b0;
        end else begin
            cmd_valid <= 1'b0;
            if (ps2_byte_valid) begin
                if (ps2_byte == SC_EXT) begin
                    ext <= 1'b1;
                end else if (ps2_byte == SC_BREAK) begin
                    brk <= 1'b1;
                end else begin
                    ext <= 1'b0;
                    brk <= 1'b0;
                    // Key releases must never move or recolour the sprite.
                    if (!brk && decoded != CMD_NONE) begin
                        cmd       <= decoded;
                        cmd_valid <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/ps2_sprite_plotter.sv
// Keyboard-driven box sprite: erases, moves and redraws a solid box one pixel per clock
// into the VGA adapter write port, with a single latest-wins pending command slot.
module ps2_sprite_plotter
    import ps2_vga_pkg::*;
#(
    parameter int SCREEN_W    = 160,
    parameter int SCREEN_H    = 120,
    parameter int X_W         = 8,
    parameter int Y_W         = 7,
    parameter int COLOUR_W    = 3,
    parameter int BOX_W       = 4,
    parameter int BOX_H       = 4,
    parameter int STEP        = 1,
    parameter int BG_COLOUR   = 0,
    parameter int INIT_COLOUR = 7
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [7:0]          ps2_byte,
    input  logic                ps2_byte_valid,
    output logic [X_W-1:0]      x,
    output logic [Y_W-1:0]      y,
    output logic [COLOUR_W-1:0] colour,
    output logic                plot,
    output logic                busy
);

    localparam int MAX_X = SCREEN_W - BOX_W;
    localparam int MAX_Y = SCREEN_H - BOX_H;
    localparam logic [X_W-1:0] CTR_X   = X_W'(MAX_X / 2);
    localparam logic [Y_W-1:0] CTR_Y   = Y_W'(MAX_Y / 2);
    localparam logic [X_W-1:0] CX_LAST = X_W'(BOX_W - 1);
    localparam logic [Y_W-1:0] CY_LAST = Y_W'(BOX_H - 1);
    localparam logic [COLOUR_W-1:0] BG   = COLOUR_W'(BG_COLOUR);
    localparam logic [COLOUR_W-1:0] INIT = COLOUR_W'(INIT_COLOUR);

    function automatic logic [COLOUR_W-1:0] next_colour(input logic [COLOUR_W-1:0] c);
        logic [COLOUR_W-1:0] n;
        n = c + COLOUR_W'(1);
        if (n == BG) n = n + COLOUR_W'(1);
        return n;
    endfunction

    cmd_t                cmd;
    logic                cmd_valid;
    cmd_t                pend;
    cmd_t                sel_cmd;
    logic                use_pend;
    state_t              state, state_next;
    logic                init_pend, prev_busy;
    logic [X_W-1:0]      pos_x, tgt_x, tgt_x_c, cx;
    logic [Y_W-1:0]      pos_y, tgt_y, tgt_y_c, cy;
    logic [COLOUR_W-1:0] spr_colour, pix_colour;
    logic                pix_plot, last_pix, moved;

    ps2_scancode_decoder u_decoder (
        .clock          (clock),
        .reset          (reset),
        .ps2_byte       (ps2_byte),
        .ps2_byte_valid (ps2_byte_valid),
        .cmd            (cmd),
        .cmd_valid      (cmd_valid)
    );

    // A pulse landing on the first IDLE cycle beats the pending slot, which then waits.
    always_comb begin
        sel_cmd  = CMD_NONE;
        use_pend = 1'b0;
        if (state == ST_IDLE && !init_pend) begin
            if (cmd_valid && (prev_busy || pend == CMD_NONE)) begin
                sel_cmd = cmd;
            end else if (pend != CMD_NONE) begin
                sel_cmd  = pend;
                use_pend = 1'b1;
            end
        end
    end

    always_comb begin
        tgt_x_c = pos_x;
        tgt_y_c = pos_y;
        case (sel_cmd)
            CMD_LEFT:   tgt_x_c = (int'(pos_x) < STEP) ? '0 : X_W'(int'(pos_x) - STEP);
            CMD_RIGHT:  tgt_x_c = (int'(pos_x) + STEP > MAX_X) ? X_W'(MAX_X) : X_W'(int'(pos_x) + STEP);
            CMD_UP:     tgt_y_c = (int'(pos_y) < STEP) ? '0 : Y_W'(int'(pos_y) - STEP);
            CMD_DOWN:   tgt_y_c = (int'(pos_y) + STEP > MAX_Y) ? Y_W'(MAX_Y) : Y_W'(int'(pos_y) + STEP);
            CMD_CENTRE: begin
                tgt_x_c = CTR_X;
                tgt_y_c = CTR_Y;
            end
            default: ;
        endcase
    end

    assign moved    = (tgt_x_c != pos_x) || (tgt_y_c != pos_y);
    assign last_pix = (cx == CX_LAST) && (cy == CY_LAST);

    always_comb begin
        state_next = state;
        pix_plot   = 1'b0;
        pix_colour = spr_colour;
        case (state)
            ST_IDLE: begin
                if (init_pend || sel_cmd == CMD_COLOUR) state_next = ST_DRAW;
                else if (sel_cmd != CMD_NONE && moved) state_next = ST_ERASE;
            end
            ST_ERASE: begin
                pix_plot   = 1'b1;
                pix_colour = BG;
                if (last_pix) state_next = ST_UPDATE;
            end
            ST_UPDATE: state_next = ST_DRAW;
            ST_DRAW: begin
                pix_plot = 1'b1;
                if (last_pix) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_next;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            x          <= '0;
            y          <= '0;
            colour     <= '0;
            plot       <= 1'b0;
            busy       <= 1'b0;
            prev_busy  <= 1'b0;
            init_pend  <= 1'b1;
            pend       <= CMD_NONE;
            pos_x      <= CTR_X;
            pos_y      <= CTR_Y;
            tgt_x      <= CTR_X;
            tgt_y      <= CTR_Y;
            cx         <= '0;
            cy         <= '0;
            spr_colour <= INIT;
        end else begin
            prev_busy <= (state != ST_IDLE);
            busy      <= (state_next != ST_IDLE);
            plot      <= pix_plot;
            if (pix_plot) begin
                x      <= pos_x + cx;
                y      <= pos_y + cy;
                colour <= pix_colour;
                if (cx == CX_LAST) begin
                    cx <= '0;
                    cy <= (cy == CY_LAST) ? '0 : cy + Y_W'(1);
                end else begin
                    cx <= cx + X_W'(1);
                end
            end
            case (state)
                ST_IDLE: begin
                    init_pend <= 1'b0;
                    tgt_x     <= tgt_x_c;
                    tgt_y     <= tgt_y_c;
                    if (sel_cmd == CMD_COLOUR) spr_colour <= next_colour(spr_colour);
                end
                ST_UPDATE: begin
                    pos_x <= tgt_x;
                    pos_y <= tgt_y;
                end
                default: ;
            endcase
            if (state != ST_IDLE || init_pend) begin
                if (cmd_valid) pend <= cmd;
            end else if (use_pend) begin
                pend <= cmd_valid ? cmd : CMD_NONE;
            end
        end
    end

endmodule

// File: tb/tb_ps2_sprite_plotter.sv
// Directed and randomized keyboard stimulus against a position/colour reference model.
module tb_ps2_sprite_plotter;

    localparam int C_UP = 1, C_DOWN = 2, C_LEFT = 3, C_RIGHT = 4, C_COLOUR = 5, C_CENTRE = 6;
    localparam int MAXX = 156, MAXY = 116, CENX = 78, CENY = 58;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] ps2_byte = 8'h00;
    logic       ps2_byte_valid = 1'b0;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
    logic       plot;
    logic       busy;

    int errors = 0;
    int checks = 0;
    int ref_x = CENX, ref_y = CENY, ref_col = 7;

    ps2_sprite_plotter dut (
        .clock          (clock),
        .reset          (reset),
        .ps2_byte       (ps2_byte),
        .ps2_byte_valid (ps2_byte_valid),
        .x              (x),
        .y              (y),
        .colour         (colour),
        .plot           (plot),
        .busy           (busy)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(posedge clock); #1;
        ps2_byte = b;
        ps2_byte_valid = 1'b1;
        @(posedge clock); #1;
        ps2_byte_valid = 1'b0;
    endtask

    task automatic send_cmd(input int c);
        case (c)
            C_UP:     begin send_byte(8'hE0); send_byte(8'h75); end
            C_DOWN:   begin send_byte(8'hE0); send_byte(8'h72); end
            C_LEFT:   begin send_byte(8'hE0); send_byte(8'h6B); end
            C_RIGHT:  begin send_byte(8'hE0); send_byte(8'h74); end
            C_COLOUR: send_byte(8'h21);
            default:  send_byte(8'h29);
        endcase
    endtask

    task automatic wait_plot(output int lat);
        bit seen = 0;
        lat = 0;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(negedge clock);
            lat++;
            if (plot === 1'b1) seen = 1;
        end
        if (!seen) lat = -1;
    endtask

    task automatic wait_noplot(input string tag);
        bit seen = 0;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(negedge clock);
            if (plot === 1'b0) seen = 1;
        end
        check(tag, {31'b0, seen}, 32'd1);
    endtask

    task automatic expect_quiet(input string tag, input int n);
        int act = 0;
        repeat (n) begin
            @(negedge clock);
            if (plot !== 1'b0 || busy !== 1'b0) act++;
        end
        check(tag, act, 0);
    endtask

    // Current negedge holds the first pixel; walks 16 pixels in raster order.
    task automatic check_box(input string tag, input int x0, input int y0, input int col);
        logic [31:0] o, e, fo, fe;
        bit bad = 0;
        fo = '0;
        fe = '0;
        for (int i = 0; i < 16; i++) begin
            if (i > 0) @(negedge clock);
            o = {13'b0, plot, colour, y, x};
            e = {13'b0, 1'b1, 3'(col), 7'(y0 + i / 4), 8'(x0 + i % 4)};
            if (!bad && o !== e) begin
                bad = 1;
                fo = o;
                fe = e;
            end
        end
        if (!bad) begin
            fo = o;
            fe = e;
        end
        check(tag, fo, fe);
    endtask

    task automatic do_cmd(input int c, input string tag);
        int nx = ref_x, ny = ref_y, ncol = ref_col, lat;
        case (c)
            C_LEFT:   nx = (ref_x < 1) ? 0 : ref_x - 1;
            C_RIGHT:  nx = (ref_x + 1 > MAXX) ? MAXX : ref_x + 1;
            C_UP:     ny = (ref_y < 1) ? 0 : ref_y - 1;
            C_DOWN:   ny = (ref_y + 1 > MAXY) ? MAXY : ref_y + 1;
            C_CENTRE: begin nx = CENX; ny = CENY; end
            default: begin
                ncol = (ref_col + 1) % 8;
                if (ncol == 0) ncol = 1;
            end
        endcase
        send_cmd(c);
        if (c == C_COLOUR) begin
            wait_plot(lat);
            check({tag, "_lat"}, lat, 3);
            check_box({tag, "_draw"}, ref_x, ref_y, ncol);
            @(negedge clock);
            check({tag, "_end"}, {30'b0, plot, busy}, 0);
        end else if (nx != ref_x || ny != ref_y) begin
            wait_plot(lat);
            check({tag, "_lat"}, lat, 3);
            check_box({tag, "_erase"}, ref_x, ref_y, 0);
            @(negedge clock);
            check({tag, "_gap"}, {30'b0, plot, busy}, 32'd1);
            @(negedge clock);
            check_box({tag, "_draw"}, nx, ny, ref_col);
            @(negedge clock);
            check({tag, "_end"}, {30'b0, plot, busy}, 0);
        end else begin
            expect_quiet({tag, "_drop"}, 8);
        end
        ref_x = nx;
        ref_y = ny;
        ref_col = ncol;
    endtask

    initial begin
        int lat;
        logic [7:0] noise [4];
        noise[0] = 8'h21; noise[1] = 8'h29; noise[2] = 8'h75; noise[3] = 8'h1C;

        repeat (3) @(negedge clock);
        check("reset_outputs", {13'b0, plot, busy, colour, y, x}, 0);

        @(posedge clock); #1;
        reset = 1'b0;
        wait_plot(lat);
        check_box("init_draw", CENX, CENY, 7);
        @(negedge clock);
        check("init_end", {30'b0, plot, busy}, 0);

        do_cmd(C_RIGHT, "right1");

        for (int i = 0; i < 80; i++) do_cmd(C_LEFT, "left_edge");
        for (int i = 0; i < 160; i++) do_cmd(C_RIGHT, "right_edge");

        do_cmd(C_COLOUR, "colour1");
        do_cmd(C_COLOUR, "colour2");

        send_byte(8'hF0); send_byte(8'h21);
        expect_quiet("break_c", 8);
        send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75);
        expect_quiet("break_up", 8);
        send_byte(8'h1C);
        expect_quiet("ignored_code", 8);

        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(3) == 0) begin
                send_byte(8'hF0);
                send_byte(noise[$urandom_range(3)]);
            end
            do_cmd($urandom_range(C_UP, C_CENTRE), "rand");
        end

        // Queue UP then LEFT while a DOWN is drawing; only LEFT should follow.
        do_cmd(C_CENTRE, "centre");
        send_cmd(C_DOWN);
        wait_plot(lat);
        check("pend_lat", lat, 3);
        check_box("pend_down_erase", ref_x, ref_y, 0);
        ref_y = ref_y + 1;
        @(negedge clock);
        send_cmd(C_UP);
        send_cmd(C_LEFT);
        wait_noplot("pend_down_done");
        wait_plot(lat);
        check_box("pend_left_erase", ref_x, ref_y, 0);
        @(negedge clock);
        check("pend_left_gap", {30'b0, plot, busy}, 32'd1);
        @(negedge clock);
        check_box("pend_left_draw", ref_x - 1, ref_y, ref_col);
        ref_x = ref_x - 1;
        expect_quiet("pend_up_dropped", 10);

        send_cmd(C_RIGHT);
        wait_plot(lat);
        repeat (3) @(negedge clock);
        #1 reset = 1'b1;
        #1 check("reset_mid_erase", {13'b0, plot, busy, colour, y, x}, 0);
        @(posedge clock); #1;
        reset = 1'b0;
        ref_x = CENX; ref_y = CENY; ref_col = 7;
        wait_plot(lat);
        check_box("redraw_centre", CENX, CENY, 7);
        expect_quiet("after_redraw", 10);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
